// File: rtl/aes_state_unloader.sv
// Captures the column-major AES state, transposes it to message order and streams 16 bytes.
// Optional sticky overrun flag is built only when AES_UNLOAD_OVERRUN_EN is defined.
module aes_state_unloader #(
    parameter int BLOCK_BYTES = 16,
    parameter int GAP_CYCLES  = 0
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         load,
    input  logic [0:127] stateIn,
    output logic [0:127] messageOut,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         tx_last,
    output logic         busy,
    output logic         overrun
);

    localparam logic [3:0] LAST_IDX = 4'(BLOCK_BYTES - 1);
    localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit         GAP_EN   = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t       state_q, state_d;
    logic [0:127] msg_q, msg_d;
    logic [3:0]   idx_q, idx_d;
    logic [7:0]   gap_q, gap_d;
    logic [7:0]   data_q, data_d;
    logic         valid_q, valid_d;
    logic         last_q, last_d;
    logic         busy_q, busy_d;

    logic [0:127] cap;
    logic [3:0]   nxt;
    logic         accept;

    // Message byte m comes from state byte 4*(m%4)+m/4; the map is its own inverse.
    function automatic logic [0:127] transpose(input logic [0:127] s);
        logic [0:127] r;
        r = '0;
        for (int m = 0; m < 16; m++) begin
            r[8*m +: 8] = s[8*(4*(m%4) + m/4) +: 8];
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        cap     = transpose(stateIn);
        accept  = valid_q && tx_ready;
        nxt     = 4'(idx_q + 4'd1);
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    msg_d   = cap;
                    idx_d   = '0;
                    data_d  = cap[0:7];
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d = nxt;
                        if (GAP_EN) begin
                            state_d = GAP;
                            gap_d   = '0;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                        end else begin
                            data_d = msg_q[{nxt, 3'b000} +: 8];
                            last_d = (nxt == LAST_IDX);
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = SEND;
                    gap_d   = '0;
                    valid_d = 1'b1;
                    data_d  = msg_q[{idx_q, 3'b000} +: 8];
                    last_d  = (idx_q == LAST_IDX);
                end else begin
                    gap_d = 8'(gap_q + 8'd1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            msg_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

`ifdef AES_UNLOAD_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb overrun_d = overrun_q | (load & busy_q);

    always_ff @(posedge CLOCK_50) begin
        if (reset) overrun_q <= 1'b0;
        else       overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign messageOut = msg_q;
    assign tx_data    = data_q;
    assign tx_valid   = valid_q;
    assign tx_last    = last_q;
    assign busy       = busy_q;

endmodule
